// File: rtl/ssd_window_loader_if.sv
// Request, frame-BRAM and result signals of ssd_window_loader.
// slave is the loader's view; master is the requester/BRAM side.
interface ssd_window_loader_if #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 320,
  parameter int BLOCK      = 6
);
  localparam int XW = $clog2(IMG_WIDTH) + 1;
  localparam int YW = $clog2(IMG_HEIGHT) + 1;

  logic                          req_valid_in;
  logic                          req_ready_out;
  logic [XW-1:0]                 left_x_in;
  logic [XW-1:0]                 right_x_in;
  logic [YW-1:0]                 left_y_in;
  logic [YW-1:0]                 right_y_in;
  logic [XW-1:0]                 left_block_idx_in;
  logic [XW-1:0]                 right_block_idx_in;
  logic [16:0]                   left_addr_out;
  logic [16:0]                   right_addr_out;
  logic [7:0]                    left_pixel_in;
  logic [7:0]                    right_pixel_in;
  logic [BLOCK-1:0][8*BLOCK-1:0] left_front_buffer;
  logic [BLOCK-1:0][8*BLOCK-1:0] left_back_buffer;
  logic [BLOCK-1:0][8*BLOCK-1:0] right_front_buffer;
  logic [BLOCK-1:0][8*BLOCK-1:0] right_back_buffer;
  logic [XW-1:0]                 left_current_x;
  logic [XW-1:0]                 right_current_x;
  logic [YW-1:0]                 left_current_y;
  logic [YW-1:0]                 right_current_y;
  logic [XW-1:0]                 left_block_idx;
  logic [XW-1:0]                 right_block_idx;
  logic                          valid_out;

  modport slave (
    input  req_valid_in, left_x_in, right_x_in, left_y_in, right_y_in,
           left_block_idx_in, right_block_idx_in, left_pixel_in, right_pixel_in,
    output req_ready_out, left_addr_out, right_addr_out,
           left_front_buffer, left_back_buffer, right_front_buffer, right_back_buffer,
           left_current_x, right_current_x, left_current_y, right_current_y,
           left_block_idx, right_block_idx, valid_out
  );

  modport master (
    output req_valid_in, left_x_in, right_x_in, left_y_in, right_y_in,
           left_block_idx_in, right_block_idx_in, left_pixel_in, right_pixel_in,
    input  req_ready_out, left_addr_out, right_addr_out,
           left_front_buffer, left_back_buffer, right_front_buffer, right_back_buffer,
           left_current_x, right_current_x, left_current_y, right_current_y,
           left_block_idx, right_block_idx, valid_out
  );
endinterface

// File: rtl/ssd_window_loader.sv
// Fetches front (x,y) and back (x+6,y) 6x6 windows from the left and right frame BRAMs.
// `LOADER_EDGE_REPLICATE_EN: clamp out-of-frame pixels to the frame edge instead of zero fill.
//
// state | meaning
// IDLE  | ready for a request, outputs hold
// ISSUE | one read per cycle per image, k = 0..71
// DRAIN | waiting for the last BRAM returns
// DONE  | valid_out pulse, buffers coherent
module ssd_window_loader #(
  parameter int IMG_WIDTH    = 240,
  parameter int IMG_HEIGHT   = 320,
  parameter int BLOCK        = 6,
  parameter int BRAM_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  ssd_window_loader_if.slave bus
);
  localparam int XW  = $clog2(IMG_WIDTH) + 1;
  localparam int YW  = $clog2(IMG_HEIGHT) + 1;
  localparam int PXW = XW + 1;
  localparam int PYW = YW + 1;
  localparam int AW  = 17;
  localparam int BW  = AW + 3;
  localparam int CW  = $clog2(BLOCK);
  localparam int DW  = $clog2(BRAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic          v;
    logic          half;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic [1:0]    oob;
  } tag_t;

  state_t        state;
  logic          ready_q;
  logic          valid_q;
  logic          half;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] drain_cnt;
  tag_t          sr [BRAM_LATENCY];
  tag_t          ret;

  logic [XW-1:0] x_in [2];
  logic [YW-1:0] y_in [2];
  logic [XW-1:0] idx_in [2];
  logic [7:0]    pix [2];
  logic [XW-1:0] x_q [2];
  logic [YW-1:0] y_q [2];
  logic [XW-1:0] idx_q [2];
  logic [BW-1:0] base0 [2];
  logic [BW-1:0] row_base [2];
  logic [AW-1:0] addr_q [2];
  logic [BLOCK-1:0][8*BLOCK-1:0] front [2];
  logic [BLOCK-1:0][8*BLOCK-1:0] back [2];

  logic [PXW-1:0] px [2];
  logic [PYW-1:0] py [2];
  logic [PXW-1:0] px_sel [2];
  logic [BW-1:0]  base_sel [2];
  logic [AW-1:0]  addr_nxt [2];
  logic [1:0]     rd_en;
  logic [1:0]     rd_oob;
`ifndef LOADER_EDGE_REPLICATE_EN
  logic [1:0]     oob;
`endif

  assign x_in[0]   = bus.left_x_in;
  assign x_in[1]   = bus.right_x_in;
  assign y_in[0]   = bus.left_y_in;
  assign y_in[1]   = bus.right_y_in;
  assign idx_in[0] = bus.left_block_idx_in;
  assign idx_in[1] = bus.right_block_idx_in;
  assign pix[0]    = bus.left_pixel_in;
  assign pix[1]    = bus.right_pixel_in;
  assign ret       = sr[BRAM_LATENCY-1];

  // Row base carries py*IMG_WIDTH, so the address is a single add per read.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      px[i] = {1'b0, x_q[i]} + PXW'(col) + (half ? PXW'(BLOCK) : PXW'(0));
      py[i] = {1'b0, y_q[i]} + PYW'(row);
`ifdef LOADER_EDGE_REPLICATE_EN
      px_sel[i]   = (px[i] >= PXW'(IMG_WIDTH)) ? PXW'(IMG_WIDTH - 1) : px[i];
      base_sel[i] = (py[i] >= PYW'(IMG_HEIGHT)) ? BW'((IMG_HEIGHT - 1) * IMG_WIDTH) : row_base[i];
      rd_en[i]    = 1'b1;
      rd_oob[i]   = 1'b0;
`else
      oob[i]      = (px[i] >= PXW'(IMG_WIDTH)) || (py[i] >= PYW'(IMG_HEIGHT));
      px_sel[i]   = px[i];
      base_sel[i] = row_base[i];
      rd_en[i]    = !oob[i];
      rd_oob[i]   = oob[i];
`endif
      addr_nxt[i] = AW'(base_sel[i] + BW'(px_sel[i]));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      half      <= 1'b0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
      for (int s = 0; s < BRAM_LATENCY; s++) sr[s] <= '0;
      for (int i = 0; i < 2; i++) begin
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        idx_q[i]    <= '0;
        base0[i]    <= '0;
        row_base[i] <= '0;
        addr_q[i]   <= '0;
        front[i]    <= '0;
        back[i]     <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      sr[0]   <= '0;
      for (int s = 1; s < BRAM_LATENCY; s++) sr[s] <= sr[s-1];

      // Out-of-frame slots still travel down the pipe so their byte is cleared.
      if (ret.v) begin
        for (int i = 0; i < 2; i++) begin
          if (ret.half) back[i][ret.r][8*ret.c +: 8]  <= pix[i] & {8{~ret.oob[i]}};
          else          front[i][ret.r][8*ret.c +: 8] <= pix[i] & {8{~ret.oob[i]}};
        end
      end

      case (state)
        IDLE: begin
          if (bus.req_valid_in) begin
            for (int i = 0; i < 2; i++) begin
              x_q[i]      <= x_in[i];
              y_q[i]      <= y_in[i];
              idx_q[i]    <= idx_in[i];
              base0[i]    <= BW'(y_in[i]) * BW'(IMG_WIDTH);
              row_base[i] <= BW'(y_in[i]) * BW'(IMG_WIDTH);
            end
            half    <= 1'b0;
            row     <= '0;
            col     <= '0;
            ready_q <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          sr[0] <= {1'b1, half, row, col, rd_oob};
          for (int i = 0; i < 2; i++)
            if (rd_en[i]) addr_q[i] <= addr_nxt[i];
          if (col == CW'(BLOCK - 1)) begin
            col <= '0;
            if (row == CW'(BLOCK - 1)) begin
              row  <= '0;
              half <= 1'b1;
              for (int i = 0; i < 2; i++) row_base[i] <= base0[i];
              if (half) begin
                state     <= DRAIN;
                drain_cnt <= DW'(BRAM_LATENCY - 1);
              end
            end else begin
              row <= row + CW'(1);
              for (int i = 0; i < 2; i++) row_base[i] <= row_base[i] + BW'(IMG_WIDTH);
            end
          end else begin
            col <= col + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_out      = ready_q;
  assign bus.valid_out          = valid_q;
  assign bus.left_addr_out      = addr_q[0];
  assign bus.right_addr_out     = addr_q[1];
  assign bus.left_front_buffer  = front[0];
  assign bus.left_back_buffer   = back[0];
  assign bus.right_front_buffer = front[1];
  assign bus.right_back_buffer  = back[1];
  assign bus.left_current_x     = x_q[0];
  assign bus.right_current_x    = x_q[1];
  assign bus.left_current_y     = y_q[0];
  assign bus.right_current_y    = y_q[1];
  assign bus.left_block_idx     = idx_q[0];
  assign bus.right_block_idx    = idx_q[1];
endmodule

// File: tb/tb_ssd_window_loader.sv
// Scoreboard bench for ssd_window_loader: window contents, latched fields,
// address stream and valid_out timing against a pixel-level reference model.
module tb_ssd_window_loader;
  localparam int W = 240;
  localparam int H = 320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_window_loader_if bus ();
  ssd_window_loader dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  typedef struct {
    int                    cyc_v;
    logic [1:0][8:0]       x;
    logic [1:0][9:0]       y;
    logic [1:0][8:0]       idx;
    logic [1:0][5:0][47:0] front;
    logic [1:0][5:0][47:0] back;
    logic [1:0][71:0][16:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_fail = 0, n_valid = 0;
  int   cyc = 0, max_addr = 0;
  int   pat = 0, seed = 0;
  int   model_held[2];
  logic [16:0] hist [2][128];

  function automatic logic [7:0] img_pix(input int im, input int addr);
    case (pat)
      0:       return (im == 0) ? 8'h64 : 8'h00;
      1:       return 8'(addr % W);
      default: return 8'(addr * 37 + im * 101 + seed);
    endcase
  endfunction

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Frame BRAM: the address the loader registers is answered one edge later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.left_pixel_in  <= img_pix(0, int'(bus.left_addr_out));
    bus.right_pixel_in <= img_pix(1, int'(bus.right_addr_out));
  end

  task automatic build_exp(input int lx, ly, lidx, rx, ry, ridx, input int cyc_v, output exp_t e);
    int xs[2];
    int ys[2];
    xs[0] = lx; xs[1] = rx; ys[0] = ly; ys[1] = ry;
    e.cyc_v = cyc_v;
    e.x[0] = 9'(lx);  e.x[1] = 9'(rx);
    e.y[0] = 10'(ly); e.y[1] = 10'(ry);
    e.idx[0] = 9'(lidx); e.idx[1] = 9'(ridx);
    e.front = '0;
    e.back  = '0;
    for (int im = 0; im < 2; im++) begin
      for (int k = 0; k < 72; k++) begin
        int h  = k / 36;
        int r  = (k % 36) / 6;
        int c  = k % 6;
        int px = xs[im] + c + 6 * h;
        int py = ys[im] + r;
        logic [7:0] b;
`ifdef LOADER_EDGE_REPLICATE_EN
        model_held[im] = ((py < H) ? py : H - 1) * W + ((px < W) ? px : W - 1);
        b = img_pix(im, model_held[im]);
`else
        if (px < W && py < H) begin
          model_held[im] = py * W + px;
          b = img_pix(im, model_held[im]);
        end else begin
          b = 8'h00;
        end
`endif
        e.addr[im][k] = 17'(model_held[im]);
        if (h == 0) e.front[im][r][8*c +: 8] = b;
        else        e.back[im][r][8*c +: 8]  = b;
      end
    end
  endtask

  task automatic check_valid();
    exp_t e;
    logic [1:0][5:0][47:0] af, ab;
    logic [16:0] act_a;
    string nm;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, expected no response", cyc);
      return;
    end
    e = sb.pop_front();
    af[0] = bus.left_front_buffer;  af[1] = bus.right_front_buffer;
    ab[0] = bus.left_back_buffer;   ab[1] = bus.right_back_buffer;
    chk("valid_cycle", 288'(cyc), 288'(e.cyc_v));
    chk("left_current_x", bus.left_current_x, e.x[0]);
    chk("right_current_x", bus.right_current_x, e.x[1]);
    chk("left_current_y", bus.left_current_y, e.y[0]);
    chk("right_current_y", bus.right_current_y, e.y[1]);
    chk("left_block_idx", bus.left_block_idx, e.idx[0]);
    chk("right_block_idx", bus.right_block_idx, e.idx[1]);
    for (int im = 0; im < 2; im++) begin
      int bad = -1;
      nm = (im == 0) ? "left" : "right";
      chk({nm, "_front_buffer"}, af[im], e.front[im]);
      chk({nm, "_back_buffer"}, ab[im], e.back[im]);
      for (int k = 0; k < 72; k++)
        if (bad < 0 && hist[im][(cyc - 73 + k) % 128] !== e.addr[im][k]) bad = k;
      if (bad < 0) bad = 0;
      act_a = hist[im][(cyc - 73 + bad) % 128];
      chk($sformatf("%s_addr_k%0d", nm, bad), act_a, e.addr[im][bad]);
    end
    n_vec++;
    if (max_addr > W * H - 1) begin
      n_fail++;
      $display("FAIL addr_bound: max address %0d, expected <= %0d", max_addr, W * H - 1);
    end
  endtask

  always @(negedge clk) begin
    hist[0][cyc % 128] = bus.left_addr_out;
    hist[1][cyc % 128] = bus.right_addr_out;
    if (int'(bus.left_addr_out) > max_addr)  max_addr = int'(bus.left_addr_out);
    if (int'(bus.right_addr_out) > max_addr) max_addr = int'(bus.right_addr_out);
    if (bus.valid_out) begin
      n_valid++;
      check_valid();
    end
  end

  task automatic drive_fields(input int lx, ly, lidx, rx, ry, ridx);
    bus.left_x_in          = 9'(lx);
    bus.left_y_in          = 10'(ly);
    bus.left_block_idx_in  = 9'(lidx);
    bus.right_x_in         = 9'(rx);
    bus.right_y_in         = 10'(ry);
    bus.right_block_idx_in = 9'(ridx);
  endtask

  task automatic issue(input int lx, ly, lidx, rx, ry, ridx, input bit hold, input bit push);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready_out && guard < 200) begin
      bus.req_valid_in = hold;
      drive_fields($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511),
                   $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511));
      guard++;
      @(negedge clk);
    end
    if (!bus.req_ready_out) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready_out=0 after %0d cycles, expected 1", guard);
      return;
    end
    bus.req_valid_in = 1'b1;
    drive_fields(lx, ly, lidx, rx, ry, ridx);
    if (push) begin
      build_exp(lx, ly, lidx, rx, ry, ridx, cyc + 75, e);
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic issue_rand(input bit hold);
    issue($urandom_range(0, 245), $urandom_range(0, 325), $urandom_range(0, 511),
          $urandom_range(0, 245), $urandom_range(0, 325), $urandom_range(0, 511), hold, 1'b1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    while ((sb.size() != 0 || !bus.req_ready_out) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, bus.req_ready_out, 1'b1);
    chk({tag, "_valid"}, bus.valid_out, 1'b0);
    chk({tag, "_left_front"}, bus.left_front_buffer, '0);
    chk({tag, "_left_back"}, bus.left_back_buffer, '0);
    chk({tag, "_right_front"}, bus.right_front_buffer, '0);
    chk({tag, "_right_back"}, bus.right_back_buffer, '0);
    chk({tag, "_left_addr"}, bus.left_addr_out, '0);
    chk({tag, "_right_addr"}, bus.right_addr_out, '0);
    chk({tag, "_left_x"}, bus.left_current_x, '0);
    chk({tag, "_right_idx"}, bus.right_block_idx, '0);
  endtask

  initial begin
    int v0;
    rst = 1'b1;
    bus.req_valid_in = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0);
    model_held[0] = 0;
    model_held[1] = 0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    pat = 0;
    issue(0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_idle();

    pat = 1;
    issue(0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    issue(0, 0, 1, 234, 0, 2, 1'b0, 1'b1);
    issue(10, 318, 3, 100, 318, 4, 1'b0, 1'b1);
    issue(239, 319, 5, 228, 314, 6, 1'b0, 1'b1);
    wait_idle();

    pat  = 2;
    seed = $urandom_range(0, 1000);
    repeat (5) issue_rand(1'b0);
    wait_idle();
    repeat (4) issue_rand(1'b1);
    wait_idle();

    // Abort at k=30 with a request raised under reset; neither may produce valid_out.
    v0 = n_valid;
    issue(3, 4, 7, 5, 6, 8, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    bus.req_valid_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_in_reset_ready", bus.req_ready_out, 1'b1);
    rst = 1'b0;
    bus.req_valid_in = 1'b0;
    model_held[0] = 0;
    model_held[1] = 0;
    @(negedge clk);
    chk_cleared("abort");
    repeat (100) @(negedge clk);
    chk("abort_no_valid", 288'(n_valid - v0), 288'(0));
    issue(12, 100, 9, 200, 50, 10, 1'b0, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
